// File: rtl/pc_fetch_controller_rv32i.sv
// pc_fetch_controller_rv32i
//   Owns the RV32I program counter and runs the instruction-fetch handshake.
//   One fetch is in flight at a time. A request is raised in REQ. The returned
//   word is held in HOLD until decode takes it. Redirects (branch, jump or
//   trap) replace the PC. A misaligned redirect parks the block in ERR until
//   an aligned redirect arrives.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   imem_req/addr         fetch request and address (the current PC)
//   imem_ack/rdata        same-cycle memory response
//   instr_valid/instr/pc  held instruction presented to decode
//   instr_ready           decode accept
//   redirect_valid/target PC load from branch/jump/trap resolution
//   misalign_err/addr     stalled on a misaligned redirect, with the bad target
//   fetch_count           accepted-instruction counter, wraps at 2^32
module pc_fetch_controller_rv32i #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        misalign_err,
   output logic [31:0] misalign_addr,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]  state;
   logic [31:0] pc;
   logic        redir_bad;
   logic        accept;

   assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
   // A handshake in HOLD counts even when a redirect flushes on the same edge.
   assign accept    = (state == S_HOLD) && instr_ready;

   // The PC only ever loads aligned values, so it drives the address directly.
   assign imem_req     = (state == S_REQ);
   assign imem_addr    = pc;
   assign instr_valid  = (state == S_HOLD);
   assign misalign_err = (state == S_ERR);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_BOOT;
         pc            <= {RESET_VECTOR[31:2], 2'b00};
         instr         <= 32'h0;
         instr_pc      <= 32'h0;
         misalign_addr <= 32'h0;
         fetch_count   <= 32'h0;
      end else begin
         if (accept)
            fetch_count <= fetch_count + 32'd1;
         case (state)
            S_BOOT: state <= S_REQ;
            S_REQ: begin
               // A redirect discards any same-cycle ack, because that data is wrong-path.
               if (redir_bad) begin
                  misalign_addr <= redirect_target;
                  state         <= S_ERR;
               end else if (redirect_valid) begin
                  pc <= redirect_target;
               end else if (imem_ack) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redir_bad) begin
                  misalign_addr <= redirect_target;
                  state         <= S_ERR;
               end else if (redirect_valid) begin
                  pc    <= redirect_target;
                  state <= S_REQ;
               end else if (instr_ready) begin
                  pc    <= pc + 32'd4;
                  state <= S_REQ;
               end
            end
            S_ERR: begin
               if (redir_bad) begin
                  misalign_addr <= redirect_target;
               end else if (redirect_valid) begin
                  pc    <= redirect_target;
                  state <= S_REQ;
               end
            end
            default: state <= S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_controller_rv32i.sv
// Bench for pc_fetch_controller_rv32i. It runs directed scenarios and then
// randomized traffic. A flag-based behavioural model of the fetch pipeline
// checks every cycle.
module tb_pc_fetch_controller_rv32i;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        misalign_err;
   logic [31:0] misalign_addr;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   pc_fetch_controller_rv32i dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .misalign_err(misalign_err), .misalign_addr(misalign_addr),
      .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   // Reference model. Each flag describes what the fetch unit is doing:
   // booting, stalled on an error, holding a word, or otherwise requesting.
   bit          m_boot, m_err, m_have;
   logic [31:0] m_pc, m_instr, m_ipc, m_maddr, m_cnt;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_step(input bit r, a, rd, rv, input logic [31:0] t, input logic [31:0] data);
      bit bad;
      bad = rv && (t % 4 != 0);
      if (r) begin
         m_boot = 1; m_err = 0; m_have = 0; m_pc = 0;
         m_instr = 0; m_ipc = 0; m_maddr = 0; m_cnt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_err) begin
         if (bad) m_maddr = t;
         else if (rv) begin m_pc = t; m_err = 0; end
      end else if (m_have) begin
         if (rd) m_cnt = m_cnt + 1;
         if (bad) begin m_err = 1; m_maddr = t; m_have = 0; end
         else if (rv) begin m_pc = t; m_have = 0; end
         else if (rd) begin m_pc = m_pc + 4; m_have = 0; end
      end else begin
         if (bad) begin m_err = 1; m_maddr = t; end
         else if (rv) m_pc = t;
         else if (a) begin m_have = 1; m_instr = data; m_ipc = m_pc; end
      end
   endtask

   task automatic compare_all();
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_boot && !m_err && !m_have});
      chk("imem_addr", imem_addr, m_pc);
      chk("addr_low", {30'b0, imem_addr[1:0]}, 32'h0);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
      chk("misalign_addr", misalign_addr, m_maddr);
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   // Entered at a negedge. Drive inputs, clock one edge, then compare at the
   // next negedge. Memory data follows the address presented.
   task automatic cyc(input bit r, a, rd, rv, input logic [31:0] t);
      logic [31:0] data;
      data = a ? (imem_addr ^ KEY) : $urandom;
      reset = r; imem_ack = a; instr_ready = rd;
      redirect_valid = rv; redirect_target = t; imem_rdata = data;
      @(posedge clock);
      model_step(r, a, rd, rv, t, data);
      @(negedge clock);
      compare_all();
   endtask

   logic [31:0] ipcs [4];
   logic [31:0] sv_instr, sv_cnt;

   initial begin
      reset = 1; imem_ack = 0; instr_ready = 0; redirect_valid = 0;
      redirect_target = 0; imem_rdata = 0;
      model_step(1, 0, 0, 0, 0, 0);
      @(negedge clock);

      // 1: reset, then sequential fetch with ack and ready tied high
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      chk("t1_req_in_reset", {31'b0, imem_req}, 0);
      cyc(0, 1, 1, 0, 0);
      chk("t1_req_after_release", {31'b0, imem_req}, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1, 0, 0);
         ipcs[i] = instr_pc;
         chk("t1_instr_data", instr, instr_pc ^ KEY);
         cyc(0, 1, 1, 0, 0);
      end
      chk("t1_ipc0", ipcs[0], 32'h0);
      chk("t1_ipc1", ipcs[1], 32'h4);
      chk("t1_ipc2", ipcs[2], 32'h8);
      chk("t1_ipc3", ipcs[3], 32'hC);
      chk("t1_next_addr", imem_addr, 32'h10);
      chk("t1_count", fetch_count, 32'd4);

      // 2: wrap-around at the top of the address space
      cyc(0, 1, 0, 1, 32'hFFFF_FFFC);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("t2_wrap_addr", imem_addr, 32'h0);
      chk("t2_no_err", {31'b0, misalign_err}, 0);

      // 3: backpressure at 0x40
      cyc(0, 0, 0, 1, 32'h40);
      cyc(0, 1, 0, 0, 0);
      sv_instr = instr;
      for (int i = 0; i < 5; i++) begin
         cyc(0, $urandom_range(0, 1), 0, 0, 0);
         chk("t3_valid", {31'b0, instr_valid}, 1);
         chk("t3_instr", instr, sv_instr);
         chk("t3_ipc", instr_pc, 32'h40);
         chk("t3_req", {31'b0, imem_req}, 0);
      end
      cyc(0, 0, 1, 0, 0);
      chk("t3_next_addr", imem_addr, 32'h44);

      // 4: redirect in REQ with a same-cycle ack at 0x8
      cyc(0, 0, 0, 1, 32'h8);
      sv_cnt = fetch_count;
      cyc(0, 1, 0, 1, 32'h100);
      chk("t4_no_present", {31'b0, instr_valid}, 0);
      chk("t4_addr", imem_addr, 32'h100);
      chk("t4_count", fetch_count, sv_cnt);
      cyc(0, 1, 0, 0, 0);
      chk("t4_ipc", instr_pc, 32'h100);

      // 5: redirect in HOLD with a same-cycle accept
      sv_cnt = fetch_count;
      cyc(0, 0, 1, 1, 32'h200);
      chk("t5_count", fetch_count, sv_cnt + 1);
      chk("t5_valid", {31'b0, instr_valid}, 0);
      chk("t5_addr", imem_addr, 32'h200);

      // 6: misaligned redirects, recovery, reset while in ERR
      cyc(0, 1, 0, 1, 32'h102);
      chk("t6_err", {31'b0, misalign_err}, 1);
      chk("t6_maddr", misalign_addr, 32'h102);
      chk("t6_req", {31'b0, imem_req}, 0);
      cyc(0, 1, 1, 1, 32'h103);
      chk("t6_maddr2", misalign_addr, 32'h103);
      cyc(0, 0, 0, 1, 32'h300);
      chk("t6_clear", {31'b0, misalign_err}, 0);
      chk("t6_addr", imem_addr, 32'h300);
      cyc(0, 0, 0, 1, 32'h301);
      cyc(1, 0, 0, 0, 0);
      chk("t6_rst_err", {31'b0, misalign_err}, 0);
      chk("t6_rst_cnt", fetch_count, 0);
      chk("t6_rst_maddr", misalign_addr, 0);
      chk("t6_rst_req", {31'b0, imem_req}, 0);

      // Randomized traffic, with occasional resets and misaligned targets
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         bit rv;
         t  = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
         rv = ($urandom_range(0, 9) == 0);
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) != 0, rv, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
